// File: rtl/pipe_if_if.sv
// pipe_if_if: instruction-memory request/acknowledge bus.
//   master (fetch stage): drives imem_addr, imem_req; samples imem_rdata, imem_ack
//   slave  (memory):      samples imem_addr, imem_req; drives imem_rdata, imem_ack
// imem_addr must stay stable while imem_req=1 and imem_ack=0. An ack in the same
// cycle as the request is legal, and the memory's ack is meaningless while
// imem_req=0.
interface pipe_if_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (output imem_addr, imem_req, input  imem_rdata, imem_ack);
    modport slave  (input  imem_addr, imem_req, output imem_rdata, imem_ack);
endinterface

// File: rtl/pipe_if.sv
// pipe_if: MIPS instruction-fetch stage. Owns the PC, runs the imem handshake,
// loads the IF/ID register and applies decode redirects after the delay slot.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   imem         pipe_if_if.master (imem_addr/imem_req out, imem_rdata/imem_ack in)
//   stall        decode cannot accept; IF/ID frozen, pcsource not consumed
//   pcsource     00 seq, 01 branch, 10 jr, 11 j/jal (for the instruction in ID)
//   imm18        branch offset (already <<2), index28 jump index (already <<2)
//   jr_addr      rs value for jr
//   instr, pc4_d, instr_valid   IF/ID register (instr_valid=0 is a bubble)
module pipe_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    pipe_if_if.master         imem,
    input  logic              stall,
    input  logic [1:0]        pcsource,
    input  logic [17:0]       imm18,
    input  logic [27:0]       index28,
    input  logic [31:0]       jr_addr,
    output logic [31:0]       instr,
    output logic [31:0]       pc4_d,
    output logic              instr_valid
);
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc, pc_plus4;
    logic [31:0] sbuf, sbuf_pc4;
    logic [31:0] tgt_reg, target;
    logic        pend;
    logic        ack, load, redir_now;

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;
    assign imem.imem_req  = ~rst & (state == FETCH);

    // Ack only counts while a request is actually out.
    assign ack       = imem.imem_req & imem.imem_ack;
    assign load      = ~stall & (((state == FETCH) & ack) | (state == HOLD));
    assign redir_now = instr_valid & (pcsource != 2'b00) & ~stall;

    always_comb begin
        target = pc4_d + {{14{imm18[17]}}, imm18};
        case (pcsource)
            2'b10:   target = jr_addr;
            2'b11:   target = {pc4_d[31:28], index28};
            default: target = pc4_d + {{14{imm18[17]}}, imm18};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            pc4_d       <= 32'd0;
            instr_valid <= 1'b0;
            pend        <= 1'b0;
            tgt_reg     <= 32'd0;
            sbuf        <= 32'd0;
            sbuf_pc4    <= 32'd0;
        end else if (load) begin
            instr       <= (state == HOLD) ? sbuf     : imem.imem_rdata;
            pc4_d       <= (state == HOLD) ? sbuf_pc4 : pc_plus4;
            instr_valid <= 1'b1;
            state       <= FETCH;
            // The word being loaded here is the delay slot of any branch in ID,
            // so the redirect (live or remembered) takes effect on the PC now.
            if (redir_now) begin
                pc <= target;
            end else if (pend) begin
                pc   <= tgt_reg;
                pend <= 1'b0;
            end else begin
                pc <= pc_plus4;
            end
        end else begin
            if (!stall) instr_valid <= 1'b0;
            // Branch leaves ID before its delay slot arrived: remember the target.
            if (redir_now) begin
                pend    <= 1'b1;
                tgt_reg <= target;
            end
            // Acked under stall: park the word, stop requesting, keep PC.
            if ((state == FETCH) && ack) begin
                sbuf     <= imem.imem_rdata;
                sbuf_pc4 <= pc_plus4;
                state    <= HOLD;
            end
        end
    end
endmodule

// File: tb/tb_pipe_if.sv
module tb_pipe_if;
    localparam logic [31:0] RPC = 32'h0040_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic [31:0] br;
        logic [1:0]  src;
        logic [17:0] imm;
        logic [27:0] idx;
        logic [31:0] jra;
        logic [31:0] tgt;
    } vec_t;

    logic        clk, rst, stall;
    logic [1:0]  pcsource;
    logic [17:0] imm18;
    logic [27:0] index28;
    logic [31:0] jr_addr, instr, pc4_d;
    logic        instr_valid;
    int          checks, errors;
    exp_t        sb[$];
    vec_t        vecs[6];

    pipe_if_if ifc();

    pipe_if #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .imem(ifc), .stall(stall), .pcsource(pcsource),
        .imm18(imm18), .index28(index28), .jr_addr(jr_addr),
        .instr(instr), .pc4_d(pc4_d), .instr_valid(instr_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign ifc.imem_rdata = mem_word(ifc.imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Settle, run the scoreboard for this cycle, then advance to the next negedge.
    task automatic cyc();
        exp_t e;
        #1;
        if (rst) begin
            sb.delete();
        end else begin
            if (instr_valid && !stall) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got pc4 %h expected none", pc4_d);
                end else begin
                    e = sb.pop_front();
                    chk("sb_instr", instr, e.instr);
                    chk("sb_pc4", pc4_d, e.pc4);
                end
            end
            if (ifc.imem_req && ifc.imem_ack)
                sb.push_back('{mem_word(ifc.imem_addr), ifc.imem_addr + 32'd4});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_id(input logic [31:0] a);
        int n;
        n = 0;
        while (!(instr_valid && pc4_d == a + 32'd4) && n < 12) begin
            cyc();
            n++;
        end
        chk("wait_id", {31'd0, instr_valid && (pc4_d == a + 32'd4)}, 32'd1);
    endtask

    // Put the word at address a into ID via a jr from whatever is in ID now.
    task automatic goto(input logic [31:0] a);
        pcsource = 2'b10;
        jr_addr  = a;
        cyc();
        pcsource = 2'b00;
        wait_id(a);
    endtask

    initial begin
        logic [31:0] a0, hold;
        checks = 0;
        errors = 0;
        vecs[0] = '{32'h0000_0100, 2'b01, 18'h00010, 28'h0, 32'h0, 32'h0000_0114};
        vecs[1] = '{32'h0000_0100, 2'b01, 18'h3FFFC, 28'h0, 32'h0, 32'h0000_0100};
        vecs[2] = '{32'h1000_0200, 2'b11, 18'h0, 28'h000_0040, 32'h0, 32'h1000_0040};
        vecs[3] = '{32'h2000_0000, 2'b10, 18'h0, 28'h0, 32'hBFC0_0010, 32'hBFC0_0010};
        vecs[4] = '{32'h0000_0000, 2'b01, 18'h20000, 28'h0, 32'h0, 32'hFFFE_0004};
        vecs[5] = '{32'hFFFF_FFF8, 2'b11, 18'h0, 28'h0AB_CDE0, 32'h0, 32'hF0AB_CDE0};

        rst = 1'b1; stall = 1'b0; pcsource = 2'b00;
        imm18 = '0; index28 = '0; jr_addr = '0; ifc.imem_ack = 1'b1;
        @(negedge clk);
        cyc();
        cyc();

        // Reset state (ack held high during reset must be ignored)
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc4", pc4_d, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, ifc.imem_req}, 32'd0);
        chk("rst_addr", ifc.imem_addr, RPC);
        chk("rst_pend", {31'd0, dut.pend}, 32'd0);

        // Streaming
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, ifc.imem_req}, 32'd1);
        chk("first_addr", ifc.imem_addr, RPC);
        cyc();
        chk("s1_addr", ifc.imem_addr, RPC + 32'd4);
        chk("s1_valid", {31'd0, instr_valid}, 32'd1);
        chk("s1_pc4", pc4_d, RPC + 32'd4);
        cyc();
        chk("s2_addr", ifc.imem_addr, RPC + 32'd8);
        chk("s2_pc4", pc4_d, RPC + 32'd8);

        // Redirect table: branch/j/jr with zero-wait delay slot
        foreach (vecs[i]) begin
            goto(vecs[i].br);
            pcsource = vecs[i].src;
            imm18    = vecs[i].imm;
            index28  = vecs[i].idx;
            jr_addr  = vecs[i].jra;
            cyc();
            pcsource = 2'b00;
            chk("vec_slot_valid", {31'd0, instr_valid}, 32'd1);
            chk("vec_slot_pc4", pc4_d, vecs[i].br + 32'd8);
            chk("vec_target", ifc.imem_addr, vecs[i].tgt);
            cyc();
        end

        // Stall across an ack: word parked, no refetch on release
        a0   = ifc.imem_addr;
        hold = instr;
        stall = 1'b1; ifc.imem_ack = 1'b0;
        cyc();
        chk("st0_req", {31'd0, ifc.imem_req}, 32'd1);
        chk("st0_addr", ifc.imem_addr, a0);
        chk("st0_instr", instr, hold);
        ifc.imem_ack = 1'b1;
        cyc();
        chk("st1_req", {31'd0, ifc.imem_req}, 32'd0);
        chk("st1_addr", ifc.imem_addr, a0);
        chk("st1_instr", instr, hold);
        chk("st1_state", {31'd0, dut.state}, 32'd1);
        cyc();
        chk("st2_req", {31'd0, ifc.imem_req}, 32'd0);
        chk("st2_instr", instr, hold);
        stall = 1'b0;
        cyc();
        chk("rel_instr", instr, mem_word(a0));
        chk("rel_pc4", pc4_d, a0 + 32'd4);
        chk("rel_addr", ifc.imem_addr, a0 + 32'd4);
        chk("rel_req", {31'd0, ifc.imem_req}, 32'd1);
        cyc();

        // Delay slot with two wait states: target remembered in pend
        goto(32'h0000_0300);
        pcsource = 2'b01; imm18 = 18'h00040; ifc.imem_ack = 1'b0;
        cyc();
        pcsource = 2'b00;
        chk("ws1_valid", {31'd0, instr_valid}, 32'd0);
        chk("ws1_addr", ifc.imem_addr, 32'h0000_0304);
        chk("ws1_pend", {31'd0, dut.pend}, 32'd1);
        cyc();
        chk("ws2_valid", {31'd0, instr_valid}, 32'd0);
        chk("ws2_pend", {31'd0, dut.pend}, 32'd1);
        ifc.imem_ack = 1'b1;
        cyc();
        chk("ws3_valid", {31'd0, instr_valid}, 32'd1);
        chk("ws3_pc4", pc4_d, 32'h0000_0308);
        chk("ws3_target", ifc.imem_addr, 32'h0000_0344);
        chk("ws3_pend", {31'd0, dut.pend}, 32'd0);
        cyc();

        // Reset with a request outstanding and a redirect pending
        goto(32'h0000_0500);
        pcsource = 2'b11; index28 = 28'h000_0800; ifc.imem_ack = 1'b0;
        cyc();
        pcsource = 2'b00;
        chk("rm_pend", {31'd0, dut.pend}, 32'd1);
        rst = 1'b1; ifc.imem_ack = 1'b1;
        cyc();
        chk("rm_instr", instr, 32'd0);
        chk("rm_pc4", pc4_d, 32'd0);
        chk("rm_valid", {31'd0, instr_valid}, 32'd0);
        chk("rm_req", {31'd0, ifc.imem_req}, 32'd0);
        chk("rm_addr", ifc.imem_addr, RPC);
        chk("rm_pend0", {31'd0, dut.pend}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rm_restart", ifc.imem_addr, RPC);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("rm_stream", ifc.imem_addr, RPC + 32'(4 * k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_if.md
# pipe_if

Instruction-fetch stage of the five-stage MIPS pipeline, sitting upstream of the decode stage. It owns the PC and runs the request/acknowledge handshake with instruction memory. It loads the IF/ID register (`instr`, `pc4_d`, `instr_valid`) that decode consumes. It applies decode's redirect (`pcsource`, `imm18`, `index28`, jr register value) after the architectural branch delay slot.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `clk` in 1: the block's only clock.
- `rst` in 1: reset, synchronous and active-high.
- `stall` in 1: decode cannot accept a new instruction; hold the IF/ID register.
- `pcsource` in 2: redirect request for the instruction currently in ID.
  - 00: sequential.
  - 01: branch.
  - 10: jr.
  - 11: j/jal.
- `imm18` in 18: branch offset, already shifted left 2.
- `index28` in 28: jump index, already shifted left 2.
- `jr_addr` in 32: rs register value, used for jr.
- `imem_addr` out 32: fetch address, equal to the PC register.
- `imem_req` out 1: fetch request.
- `imem_rdata` in 32: instruction word, valid when `imem_ack` is high.
- `imem_ack` in 1: request completes this cycle.
- `instr` out 32: IF/ID instruction.
- `pc4_d` out 32: PC+4 of `instr`.
- `instr_valid` out 1: `instr` is a real instruction; 0 means bubble.

## Operation
- **States**
  - FETCH: `imem_req`=1.
  - HOLD: `imem_req`=0. A fetched word is parked in the one-entry skid buffer `sbuf`/`sbuf_pc4`.
- **Memory handshake**
  - `imem_addr` stays stable while `imem_req`=1 and `imem_ack`=0.
  - Ack in the same cycle as the request (zero wait) is legal.
  - `imem_ack` is ignored when `imem_req`=0.
- **load**: true when (FETCH & `imem_ack` & ~`stall`) or (HOLD & ~`stall`).
  - On load: `instr` ← word (or `sbuf`), `pc4_d` ← PC+4 of that word, `instr_valid` ← 1.
- **FETCH & `imem_ack` & `stall`**: word goes into `sbuf`, PC is unchanged, next state is HOLD.
- **HOLD & ~`stall`**: load from `sbuf`, advance PC, next state is FETCH.
- **~`stall` & ~load**: `instr_valid` ← 0 (bubble). `instr` and `pc4_d` hold their last values.
- **`stall`=1**:
  - IF/ID is frozen.
  - `pcsource` is not consumed. It is re-evaluated when the stall releases.
- **Redirect capture**: `redir_now` = `instr_valid` & (`pcsource`≠00) & ~`stall`.
  - Target arithmetic is mod 2^32.
  - 01: `pc4_d` + sign-extended `imm18`, i.e. {14{`imm18`[17]}, `imm18`}.
  - 10: `jr_addr`, used verbatim.
  - 11: {`pc4_d`[31:28], `index28`}.
- **Delay slot**: the word at `pc4_d` of the branch is always fetched and passed to ID. It is never flushed.
- **PC update on load**, in priority order:
  1. `redir_now` → target.
  2. Else `pend` → `tgt_reg`, and `pend` ← 0.
  3. Else PC+4.
- **Redirect with no load**: if `redir_now` and no load occurs (delay slot not yet acked), then `pend` ← 1 and `tgt_reg` ← target. The branch leaving ID does not lose its target.
- `pend` and `redir_now` never both apply, because a branch is never in a delay slot.

## Timing
- **Reset values**:
  - PC = `RESET_PC`.
  - `instr` = 0, `pc4_d` = 0, `instr_valid` = 0.
  - `pend` = 0, `tgt_reg` = 0, `sbuf` = 0.
  - State = FETCH.
- `imem_req` is forced to 0 while `rst`=1.
- Reset overrides everything, including an ack or a pending redirect in the same cycle. An ack arriving during reset is discarded.
- First request is in the cycle after `rst` falls, with `imem_addr`=`RESET_PC`.
- **Throughput**:
  - One instruction per cycle with zero-wait memory and no stall.
  - Word acked in cycle n appears on `instr` in cycle n+1.
- **Redirect latency**:
  - Branch in ID at cycle n with the delay slot acked at n: `imem_addr`=target at n+1.
  - Delay slot acked at n+k: `imem_addr`=target at n+k+1.
- After a stall releases from HOLD, the buffered word is on `instr` the next cycle. The same address is never refetched.

## Test plan
1. **Reset and streaming.** `RESET_PC`=`32'h0040_0000`, `imem_ack` tied 1, no stall → `imem_addr` reads `0x00400000`, `0x00400004`, `0x00400008` on consecutive cycles. `instr_valid`=1 from the first post-reset load. `pc4_d` trails the address by +4.
2. **Branch.** Branch at `0x100` in ID with `pcsource`=01 and `imm18`=`0x00010` → delay slot `0x104` is loaded, next `imem_addr`=`0x114`. Repeat with `imm18`=`0x3FFFC` → target `0x100`.
3. **j and jr.**
   - j: `pc4_d`=`0x1000_0204`, `index28`=`0x000_0040` → next fetch `0x1000_0040`.
   - jr: `jr_addr`=`0xBFC0_0010` → next fetch `0xBFC0_0010`.
4. **Stall during ack.** `stall`=1 for 3 cycles, ack arrives in cycle 1 → state HOLD, `imem_req`=0, `instr` unchanged. On stall release, the buffered word appears next cycle and `imem_addr` advances by exactly +4 with no refetch.
5. **Wait states on the delay slot.** Branch in ID, delay-slot ack delayed 2 cycles → `instr_valid`=0 for 2 cycles, `pend`=1. After the delay slot loads, `imem_addr`=branch target and `pend`=0.
6. **Reset mid-operation.** `rst` asserted while a request is outstanding and `pend`=1 → all outputs at reset values the next cycle. Fetch restarts at `RESET_PC` and the old target is never issued.
